demux_1_4_rr: RTL and testbench

- Registered 1-to-4 demultiplexer. It is the distribution-side counterpart of the mux_4_1 selection path: one input stream is fanned out to four output lanes.
- Each beat is routed either by an explicit lane select or by an internal round-robin pointer.
- Each lane holds one beat in a skid-free output register with a valid/ready handshake.
- It sits between a single producer and four lane consumers in the datapath.

---
 rtl/demux_1_4_rr_if.sv | 31 +++
 rtl/demux_1_4_rr.sv | 77 +++++++
 tb/tb_demux_1_4_rr.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/demux_1_4_rr_if.sv
// Bundle of the demux_1_4_rr producer-side and lane-side handshake signals.
// Handshake: a beat moves on a port when its valid and ready are both high at a rising clk edge;
// valid may rise without waiting for ready, and once high, payload and valid stay stable until the transfer.
interface demux_1_4_rr_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;
  logic             mode;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [WIDTH-1:0] out_data0;
  logic [WIDTH-1:0] out_data1;
  logic [WIDTH-1:0] out_data2;
  logic [WIDTH-1:0] out_data3;
  logic [1:0]       rr_ptr;

  // Environment side: the producer and the four lane consumers.
  modport master (
    output in_valid, in_data, in_sel, mode, out_ready,
    input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3, rr_ptr
  );

  // Demux side.
  modport slave (
    input  in_valid, in_data, in_sel, mode, out_ready,
    output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3, rr_ptr
  );
endinterface

// File: rtl/demux_1_4_rr.sv
// Registered 1-to-4 demux, addressed or round-robin, one beat held per lane.
// Optional macro DEMUX_RR_SKIP_FULL_EN: in round-robin mode skip lanes that are full and not draining.
module demux_1_4_rr #(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  demux_1_4_rr_if.slave     bus
);
  logic [3:0]       valid_q;
  logic [WIDTH-1:0] data_q [4];
  logic [1:0]       rr_ptr_q;

  logic [3:0]       lane_free;
  logic [1:0]       tgt;
  logic             rdy;
  logic             acc;
  logic [3:0]       load;
`ifdef DEMUX_RR_SKIP_FULL_EN
  logic [1:0]       idx;
`endif

  // A lane can take a beat if it is empty or its consumer drains it this cycle.
  assign lane_free = ~valid_q | bus.out_ready;

`ifdef DEMUX_RR_SKIP_FULL_EN
  always_comb begin
    tgt = bus.in_sel;
    rdy = lane_free[bus.in_sel];
    idx = rr_ptr_q;
    if (bus.mode) begin
      tgt = rr_ptr_q;
      rdy = 1'b0;
      // Walk from the far end back so the lane closest to rr_ptr wins.
      for (int k = 3; k >= 0; k--) begin
        idx = rr_ptr_q + 2'(k);
        if (lane_free[idx]) begin
          tgt = idx;
          rdy = 1'b1;
        end
      end
    end
  end
`else
  always_comb begin
    tgt = bus.mode ? rr_ptr_q : bus.in_sel;
    rdy = lane_free[tgt];
  end
`endif

  assign acc  = bus.in_valid & rdy;
  assign load = acc ? (4'b0001 << tgt) : 4'b0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 4'b0000;
      rr_ptr_q <= 2'd0;
      for (int i = 0; i < 4; i++) data_q[i] <= '0;
    end else begin
      // A load wins over a drain, so a lane can stream one beat per cycle.
      valid_q <= load | (valid_q & ~bus.out_ready);
      for (int i = 0; i < 4; i++) begin
        if (load[i]) data_q[i] <= bus.in_data;
      end
      // tgt equals rr_ptr in strict mode, so tgt+1 covers both builds.
      if (acc && bus.mode) rr_ptr_q <= tgt + 2'd1;
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = valid_q;
  assign bus.out_data0 = data_q[0];
  assign bus.out_data1 = data_q[1];
  assign bus.out_data2 = data_q[2];
  assign bus.out_data3 = data_q[3];
  assign bus.rr_ptr    = rr_ptr_q;
endmodule

// File: tb/tb_demux_1_4_rr.sv
// Directed bench for demux_1_4_rr with hand-computed expectations.
module tb_demux_1_4_rr;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [W-1:0] exp_q[$];

  demux_1_4_rr_if #(.WIDTH(W)) bus ();

  demux_1_4_rr #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic [1:0] s, input logic m);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_sel   = s;
    bus.mode     = m;
    #1;
  endtask

  function automatic logic [W-1:0] lane_data(input int i);
    case (i)
      0:       return bus.out_data0;
      1:       return bus.out_data1;
      2:       return bus.out_data2;
      default: return bus.out_data3;
    endcase
  endfunction

  initial begin
    logic [W-1:0] vals [4];
    logic [W-1:0] e;
    vals = '{4'hA, 4'hB, 4'hC, 4'hD};
    bus.out_ready = 4'b1111;
    drive(1'b0, '0, 2'd0, 1'b0);

    // reset state
    #2;
    chk("rst_valid", bus.out_valid, 4'b0000);
    chk("rst_ptr", bus.rr_ptr, 0);
    chk("rst_data", {bus.out_data0, bus.out_data1, bus.out_data2, bus.out_data3}, 0);
    chk("rst_ready", bus.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // addressed mode, A..D to lanes 0..3
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, vals[i], 2'(i), 1'b0);
      chk("addr_ready", bus.in_ready, 1);
      step();
      chk("addr_valid", bus.out_valid[i], 1);
      chk("addr_data", lane_data(i), vals[i]);
    end
    drive(1'b0, '0, 2'd0, 1'b0);
    step();
    chk("addr_drained", bus.out_valid, 4'b0000);
    chk("addr_hold", {bus.out_data0, bus.out_data1, bus.out_data2, bus.out_data3}, 16'hABCD);

    // round-robin, beats 1..6 to lanes 0,1,2,3,0,1
    for (int i = 1; i <= 6; i++) exp_q.push_back(4'(i));
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 4'(i + 1), 2'd3, 1'b1);
      step();
      e = exp_q.pop_front();
      chk("rr_data", lane_data(i % 4), e);
      chk("rr_valid", bus.out_valid, 4'b0001 << (i % 4));
    end
    drive(1'b0, '0, 2'd0, 1'b1);
    chk("rr_ptr_end", bus.rr_ptr, 2);
    step();

    // backpressure on lane 2
    bus.out_ready = 4'b1011;
    drive(1'b1, 4'd7, 2'd2, 1'b0);
    chk("bp_first_ready", bus.in_ready, 1);
    step();
    chk("bp_valid7", bus.out_valid[2], 1);
    chk("bp_data7", bus.out_data2, 7);
    drive(1'b1, 4'd9, 2'd2, 1'b0);
    chk("bp_stall", bus.in_ready, 0);
    step();
    chk("bp_hold7", bus.out_data2, 7);
    bus.out_ready = 4'b1111;
    #1;
    chk("bp_release", bus.in_ready, 1);
    step();
    chk("bp_data9", bus.out_data2, 9);
    chk("bp_valid9", bus.out_valid[2], 1);
    drive(1'b0, '0, 2'd0, 1'b0);
    step();

    // full lane 1 at rr_ptr=1 in round-robin mode
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    step();
    bus.out_ready = 4'b1101;
    drive(1'b1, 4'd3, 2'd1, 1'b0);
    step();
    drive(1'b1, 4'd4, 2'd0, 1'b1);
    step();
    chk("blk_setup_ptr", bus.rr_ptr, 1);
    chk("blk_setup_valid1", bus.out_valid[1], 1);
    drive(1'b1, 4'd8, 2'd0, 1'b1);
`ifdef DEMUX_RR_SKIP_FULL_EN
    chk("skip_ready", bus.in_ready, 1);
    step();
    chk("skip_data2", bus.out_data2, 8);
    chk("skip_ptr", bus.rr_ptr, 3);
    chk("skip_lane1_kept", bus.out_data1, 3);
    drive(1'b0, '0, 2'd0, 1'b1);
    bus.out_ready = 4'b1111;
    step();
`else
    chk("blk_ready", bus.in_ready, 0);
    step();
    chk("blk_ptr", bus.rr_ptr, 1);
    chk("blk_lane1_kept", bus.out_data1, 3);
    bus.out_ready = 4'b1111;
    #1;
    chk("blk_release", bus.in_ready, 1);
    step();
    chk("blk_data1", bus.out_data1, 8);
    chk("blk_ptr2", bus.rr_ptr, 2);
    drive(1'b0, '0, 2'd0, 1'b1);
    step();
`endif

    // asynchronous reset with lanes 0 and 3 full
    bus.out_ready = 4'b0000;
    drive(1'b1, 4'd1, 2'd0, 1'b0);
    step();
    drive(1'b1, 4'd2, 2'd3, 1'b0);
    step();
    drive(1'b0, '0, 2'd3, 1'b0);
    chk("ar_full", bus.out_valid, 4'b1001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", bus.out_valid, 4'b0000);
    chk("ar_ptr", bus.rr_ptr, 0);
    #1;
    rst_n = 1'b1;
    step();
    drive(1'b1, 4'd5, 2'd3, 1'b0);
    chk("ar_first_ready", bus.in_ready, 1);
    step();
    chk("ar_valid3", bus.out_valid, 4'b1000);
    chk("ar_data3", bus.out_data3, 5);
    drive(1'b0, '0, 2'd0, 1'b0);
    bus.out_ready = 4'b1111;
    step();

    // mode switch keeps rr_ptr
    drive(1'b1, 4'd1, 2'd0, 1'b1);
    step();
    drive(1'b1, 4'd2, 2'd0, 1'b1);
    step();
    chk("ms_ptr2", bus.rr_ptr, 2);
    drive(1'b1, 4'd3, 2'd0, 1'b0);
    step();
    chk("ms_addr_data0", bus.out_data0, 3);
    chk("ms_ptr_held", bus.rr_ptr, 2);
    drive(1'b1, 4'd4, 2'd0, 1'b1);
    step();
    chk("ms_rr_data2", bus.out_data2, 4);
    chk("ms_rr_valid", bus.out_valid, 4'b0100);
    chk("ms_ptr3", bus.rr_ptr, 3);
    drive(1'b0, '0, 2'd0, 1'b0);
    step();

    // report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
